// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder slice walks two operands
// LSB to MSB and returns a registered sum/carry with a done pulse.

module serial_add_ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             cf_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             h0_s;
    logic             h0_c;
    logic             s_bit;
    logic             h1_c;
    logic             c_bit;
    logic             last;
    logic [WIDTH-1:0] sr_d;
    logic             unused_sr;

    // Full adder built from two half-adder cells plus an OR on the carries
    serial_add_ha u_ha0 (
        .x (sa_q[0]),
        .y (sb_q[0]),
        .s (h0_s),
        .c (h0_c)
    );

    serial_add_ha u_ha1 (
        .x (h0_s),
        .y (cf_q),
        .s (s_bit),
        .c (h1_c)
    );

    assign c_bit     = h0_c | h1_c;
    assign last      = (cnt_q == CW'(WIDTH - 1));
    assign sr_d      = {s_bit, sr_q[WIDTH-1:1]};
    assign unused_sr = sr_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cf_q    <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        cf_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    sr_q  <= sr_d;
                    cf_q  <= c_bit;
                    cnt_q <= cnt_q + CW'(1);
                    // Result registers only move on the final bit
                    if (last) begin
                        sum_q   <= sr_d;
                        cout_q  <= c_bit;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl at WIDTH=8 and WIDTH=16.

module tb_serial_add_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st = 1'b0;
    logic        sel16 = 1'b0;
    logic [15:0] ad = '0;
    logic [15:0] bd = '0;

    logic        st8;
    logic        st16;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;
    logic        cbusy, cdone;
    logic [32:0] cres;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          dcyc[$];
    logic [32:0] dres[$];

    assign st8   = st & ~sel16;
    assign st16  = st & sel16;
    assign cbusy = sel16 ? busy16 : busy8;
    assign cdone = sel16 ? done16 : done8;
    assign cres  = sel16 ? {16'd0, cout16, sum16} : {24'd0, cout8, sum8};

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (st8),
        .a     (ad[7:0]),
        .b     (bd[7:0]),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_add_ctrl #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (st16),
        .a     (ad),
        .b     (bd),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("excl8", {63'd0, busy8 & done8}, 64'd0);
        chk("excl16", {63'd0, busy16 & done16}, 64'd0);
        if (done8) begin
            dcyc.push_back(cyc);
            dres.push_back({24'd0, cout8, sum8});
        end
        if (done16) begin
            dcyc.push_back(cyc);
            dres.push_back({16'd0, cout16, sum16});
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] a, input logic [15:0] b);
        ad = a;
        bd = b;
        st = 1'b1;
        step();
        st = 1'b0;
    endtask

    task automatic op8(input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic [8:0] exp,
                       input logic [8:0] prev);
        int nb;
        int dat;
        logic hold_ok;
        nb = 0;
        dat = -1;
        hold_ok = 1'b1;
        dcyc.delete();
        dres.delete();
        go({8'd0, a}, {8'd0, b});
        for (int i = 0; i < 12; i++) begin
            if (busy8) nb++;
            if (done8 && dat < 0) dat = i;
            if (i < 8 && {cout8, sum8} !== prev) hold_ok = 1'b0;
            step();
        end
        chk({tag, ".busy"}, nb, 8);
        chk({tag, ".dpos"}, dat, 8);
        chk({tag, ".ndone"}, dres.size(), 1);
        chk({tag, ".hold"}, {63'd0, hold_ok}, 64'd1);
        chk({tag, ".res"}, {cout8, sum8}, exp);
    endtask

    task automatic rnd(input int w, input int n);
        logic [32:0] mask;
        logic [32:0] ra, rb, exp;
        int t;
        sel16 = (w == 16);
        mask = (33'd1 << w) - 33'd1;
        for (int k = 0; k < n; k++) begin
            ra = {1'b0, $urandom} & mask;
            rb = {1'b0, $urandom} & mask;
            exp = ra + rb;
            dcyc.delete();
            dres.delete();
            go(ra[15:0], rb[15:0]);
            if ($urandom_range(0, 49) == 0) begin
                repeat ($urandom_range(0, w - 2)) step();
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk("rnd.rbusy", {63'd0, cbusy}, 64'd0);
                chk("rnd.rdone", {63'd0, cdone}, 64'd0);
                chk("rnd.rres", cres, 64'd0);
                repeat (w + 2) step();
                chk("rnd.nodone", dres.size(), 0);
            end else begin
                t = 0;
                while (dres.size() == 0 && t < w + 4) begin
                    step();
                    t++;
                end
                chk("rnd.seen", dres.size(), 1);
                if (dres.size() > 0) chk("rnd.sum", dres[0], exp);
                repeat ($urandom_range(0, 3)) step();
            end
        end
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst.busy", {63'd0, busy8}, 64'd0);
        chk("rst.done", {63'd0, done8}, 64'd0);
        chk("rst.res", {cout8, sum8}, 64'd0);
        step();

        op8("add1", 8'h5A, 8'h3C, 9'h096, 9'h000);
        op8("add2", 8'hFF, 8'h01, 9'h100, 9'h096);
        op8("add3", 8'hFF, 8'hFF, 9'h1FE, 9'h100);

        dcyc.delete();
        dres.delete();
        go(16'h0011, 16'h0022);
        step();
        step();
        ad = 16'h00AA;
        bd = 16'h0055;
        st = 1'b1;
        step();
        st = 1'b0;
        repeat (12) step();
        chk("ign.ndone", dres.size(), 1);
        chk("ign.res", {cout8, sum8}, 9'h033);

        dcyc.delete();
        dres.delete();
        go(16'h0080, 16'h0080);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort.busy", {63'd0, busy8}, 64'd0);
        chk("abort.done", {63'd0, done8}, 64'd0);
        chk("abort.res", {cout8, sum8}, 64'd0);
        repeat (12) step();
        chk("abort.nodone", dres.size(), 0);
        op8("fresh", 8'h80, 8'h80, 9'h100, 9'h000);

        dcyc.delete();
        dres.delete();
        ad = 16'h0001;
        bd = 16'h0002;
        st = 1'b1;
        step();
        ad = 16'h0003;
        bd = 16'h0004;
        repeat (9) step();
        st = 1'b0;
        repeat (12) step();
        chk("b2b.ndone", dres.size(), 2);
        if (dres.size() == 2) begin
            chk("b2b.gap", dcyc[1] - dcyc[0], 9);
            chk("b2b.res0", dres[0], 33'h003);
            chk("b2b.res1", dres[1], 33'h007);
        end

        rnd(8, 500);
        rnd(16, 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder sequencer. Adds two WIDTH-bit operands one bit per clock through a single full-adder slice.
- The slice is two half-adder cells plus an OR for carry-out. A carry flop holds the carry between bits.
- Sits between a requesting master and the shared 1-bit add datapath. Captures operands on start, walks LSB to MSB, and presents a registered sum/carry with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous, active-high reset
start  input   1      request; sampled only in IDLE or DONE
a      input   WIDTH  operand A; captured on the accepting edge
b      input   WIDTH  operand B; captured on the accepting edge
busy   output  1      high while state is RUN
done   output  1      one-cycle pulse; sum/cout valid
sum    output  WIDTH  registered result, held until the next completion
cout   output  1      registered final carry, held with sum

Behaviour:
- State machine, 2-bit encoding: IDLE, RUN, DONE.
- Internal registers:
  - shift registers sa, sb (WIDTH each)
  - result shift register sr (WIDTH)
  - carry flop cf
  - bit counter cnt, $clog2(WIDTH+1) bits
- Reset (rst=1 at an edge): overrides everything, including start.
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - cf=0, cnt=0; sa/sb/sr=0.
- IDLE or DONE with start=1 (accepting edge E0):
  - sa<=a, sb<=b, cf<=0, cnt<=0, state<=RUN.
- IDLE or DONE with start=0:
  - DONE goes to IDLE; IDLE stays in IDLE.
- RUN, each edge:
  - Bit slice: s = sa[0]^sb[0]^cf; c = (sa[0]&sb[0]) | (cf&(sa[0]^sb[0])).
  - sa, sb shift right by 1, zero fill.
  - sr <= {s, sr[WIDTH-1:1]}; cf <= c; cnt <= cnt+1.
- RUN, completion edge (cnt==WIDTH-1, the last bit):
  - sum <= {s, sr[WIDTH-1:1]}, cout <= c, state <= DONE.
- Latency: the accepting edge is E0, and bit i is processed at edge E(i+1). done rises after edge E(WIDTH) and is high for exactly one cycle.
- busy is high in the cycles after E0 through E(WIDTH-1), i.e. WIDTH cycles.
- sum/cout change only at the completion edge. They are stable during RUN and keep the previous result until the next completion.
- start while in RUN: ignored. No queuing, no error flag; a/b changes during RUN have no effect.
- start held high continuously: a new operation is accepted in the DONE cycle (back-to-back). Throughput is one add per WIDTH+1 cycles.
- Reset mid-RUN: the operation is abandoned. The next cycle shows busy=0 and done=0, and sum/cout read 0. No done pulse is issued for the aborted request.
- Unsigned arithmetic: {cout,sum} == a+b modulo 2^(WIDTH+1). No overflow flag.
- done and busy are never high in the same cycle.

Test Plan:
- WIDTH=8: a=0x5A, b=0x3C, start pulsed at E0 -> busy high for 8 cycles; done high only in the cycle after E8; sum=0x96, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF -> sum=0xFE, cout=1; the earlier result is held until this completion edge.
- start first accepted with a=0x11, b=0x22, then pulsed again at E3 with a=0xAA, b=0x55 -> second request ignored; result sum=0x33, cout=0; exactly one done pulse.
- Operation a=0x80, b=0x80; rst=1 at E4 -> busy=0, done=0, sum=0x00, cout=0 next cycle; no done pulse in the following 12 cycles; a fresh start then gives a correct result.
- start held high with operands 0x01+0x02, then 0x03+0x04 -> done pulses spaced 9 cycles apart; sums 0x03 then 0x07.
- 1000 random a/b pairs, WIDTH=8 and WIDTH=16, random start gaps and a random rst every ~50 ops -> every done matches {cout,sum}==a+b of the accepted request; done and busy never both high.
